// File: rtl/axis_ad5791_cfg_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// axis_ad5791_cfg_seq
//
// Purpose:
//   Walks a fixed AD5791 register word out to each DAC axis in turn through a
//   downstream SPI driver. A run starts on a rising edge of 'start'. For each
//   axis the sequencer presents the word and the axis index, lets them settle,
//   pulses a send request and then follows the driver's 'dac_ready' handshake.
//   If the driver never acknowledges a send, that axis is marked as skipped. If
//   the driver acknowledges but never finishes, the run is aborted with a
//   sticky error flag.
//
// Ports:
//   a_clk              in   system clock (125 MHz)
//   a_rst              in   synchronous active-high reset
//   start              in   run request, rising edge starts a sequence
//   ctrl_word[23:0]    in   register word sent to every axis, latched at start
//   dac_ready          in   downstream SPI driver idle flag
//   M_AXISCFG_tdata    out  zero-extended latched ctrl_word
//   M_AXISCFG_tvalid   out  config data valid
//   configuration_mode out  holds the downstream driver in config mode
//   configuration_axis out  axis index currently being written
//   configuration_send out  send request to the downstream driver
//   busy               out  high from start acceptance until the run ends
//   done               out  one-cycle pulse at the end of a run
//   error              out  sticky "driver never finished a frame" flag
//   skipped[3:0]       out  bit n set when axis n produced no SPI frame
// -----------------------------------------------------------------------------
module axis_ad5791_cfg_seq #(
   parameter int NUM_AXES          = 4,
   parameter int SAXIS_TDATA_WIDTH = 32,
   parameter int SETTLE_CYCLES     = 16,
   parameter int ACK_TIMEOUT       = 64,
   parameter int DONE_TIMEOUT      = 511
) (
   input  logic                         a_clk,
   input  logic                         a_rst,
   input  logic                         start,
   input  logic [23:0]                  ctrl_word,
   input  logic                         dac_ready,
   output logic [SAXIS_TDATA_WIDTH-1:0] M_AXISCFG_tdata,
   output logic                         M_AXISCFG_tvalid,
   output logic                         configuration_mode,
   output logic [2:0]                   configuration_axis,
   output logic                         configuration_send,
   output logic                         busy,
   output logic                         done,
   output logic                         error,
   output logic [3:0]                   skipped
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SETTLE,
      SEND,
      WAIT_ACK,
      WAIT_DONE,
      NEXT,
      FINISH
   } state_t;

   // The counter compares against "last cycle" values so that a state lasting
   // N cycles sees the counter run 0..N-1 and leaves on the N-th cycle.
   localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
   localparam logic [31:0] ACK_LAST    = 32'(ACK_TIMEOUT - 1);
   localparam logic [31:0] DONE_LAST   = 32'(DONE_TIMEOUT - 1);
   localparam logic [2:0]  LAST_AXIS   = 3'(NUM_AXES - 1);

   state_t      state;
   logic        start_prev;
   logic        start_edge;
   logic [31:0] cycle_cnt;

   // A run request is a 0->1 transition of start. The history register is
   // cleared by reset, so a start held high across reset release is seen as
   // a fresh edge on the first cycle out of reset.
   assign start_edge = start & ~start_prev;

   // Sequencer. Every output is a register and is updated on the transition
   // into the state that owns it, so the output value always matches the
   // current state with no combinational decode on the output pins. The
   // general-purpose cycle counter is cleared on every state change and only
   // advances while a state is waiting for time or for the driver.
   // The data word and axis index are only ever written on the way into LOAD,
   // which keeps them frozen across settle, send and the handshake.
   // 'done' is a one-cycle pulse: it is raised on entry to FINISH and the
   // default assignment drops it again on the next cycle.
   always_ff @(posedge a_clk) begin
      if (a_rst) begin
         state              <= IDLE;
         start_prev         <= 1'b0;
         cycle_cnt          <= '0;
         M_AXISCFG_tdata    <= '0;
         M_AXISCFG_tvalid   <= 1'b0;
         configuration_mode <= 1'b0;
         configuration_axis <= '0;
         configuration_send <= 1'b0;
         busy               <= 1'b0;
         done               <= 1'b0;
         error              <= 1'b0;
         skipped            <= '0;
      end else begin
         start_prev <= start;
         done       <= 1'b0;

         case (state)
            IDLE: begin
               cycle_cnt <= '0;
               if (start_edge && dac_ready) begin
                  state              <= LOAD;
                  M_AXISCFG_tdata    <= SAXIS_TDATA_WIDTH'(ctrl_word);
                  M_AXISCFG_tvalid   <= 1'b1;
                  configuration_mode <= 1'b1;
                  configuration_axis <= '0;
                  configuration_send <= 1'b0;
                  busy               <= 1'b1;
                  error              <= 1'b0;
                  skipped            <= '0;
               end
            end

            LOAD: begin
               state     <= SETTLE;
               cycle_cnt <= '0;
            end

            SETTLE: begin
               if (cycle_cnt == SETTLE_LAST) begin
                  state              <= SEND;
                  cycle_cnt          <= '0;
                  configuration_send <= 1'b1;
               end else begin
                  cycle_cnt <= cycle_cnt + 32'd1;
               end
            end

            SEND: begin
               state     <= WAIT_ACK;
               cycle_cnt <= '0;
            end

            WAIT_ACK: begin
               if (!dac_ready) begin
                  state              <= WAIT_DONE;
                  cycle_cnt          <= '0;
                  configuration_send <= 1'b0;
               end else if (cycle_cnt == ACK_LAST) begin
                  state                        <= NEXT;
                  cycle_cnt                    <= '0;
                  configuration_send           <= 1'b0;
                  skipped[configuration_axis[1:0]] <= 1'b1;
               end else begin
                  cycle_cnt <= cycle_cnt + 32'd1;
               end
            end

            WAIT_DONE: begin
               if (dac_ready) begin
                  state     <= NEXT;
                  cycle_cnt <= '0;
               end else if (cycle_cnt == DONE_LAST) begin
                  state              <= FINISH;
                  cycle_cnt          <= '0;
                  error              <= 1'b1;
                  M_AXISCFG_tvalid   <= 1'b0;
                  configuration_mode <= 1'b0;
                  done               <= 1'b1;
               end else begin
                  cycle_cnt <= cycle_cnt + 32'd1;
               end
            end

            NEXT: begin
               cycle_cnt <= '0;
               if (configuration_axis == LAST_AXIS) begin
                  state              <= FINISH;
                  M_AXISCFG_tvalid   <= 1'b0;
                  configuration_mode <= 1'b0;
                  done               <= 1'b1;
               end else begin
                  state              <= LOAD;
                  configuration_axis <= configuration_axis + 3'd1;
               end
            end

            FINISH: begin
               state     <= IDLE;
               cycle_cnt <= '0;
               busy      <= 1'b0;
            end

            default: begin
               state     <= IDLE;
               cycle_cnt <= '0;
            end
         endcase
      end
   end

   // A send request must always be accompanied by valid config data, and a
   // run never reports completion while a request is still outstanding.
   assert property (@(posedge a_clk) disable iff (a_rst)
      configuration_send |-> M_AXISCFG_tvalid);

   assert property (@(posedge a_clk) disable iff (a_rst)
      done |-> !configuration_send);

endmodule

// File: tb/tb_axis_ad5791_cfg_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_axis_ad5791_cfg_seq
//
// Purpose:
//   Self-checking bench for axis_ad5791_cfg_seq. A downstream SPI driver model
//   answers each send request according to a per-axis plan (acknowledge delay,
//   busy time, or "never"). The expected outcome of every run is derived from
//   that plan alone: which axes produce frames, how long each send request is
//   held, which axes end up skipped and whether the run ends in error.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_axis_ad5791_cfg_seq;

   localparam int NUM_AXES     = 4;
   localparam int ACK_TIMEOUT  = 64;
   localparam int DONE_TIMEOUT = 511;
   localparam int MIN_SETTLE   = 16;

   logic        a_clk;
   logic        a_rst;
   logic        start;
   logic [23:0] ctrl_word;
   logic        dac_ready;
   logic [31:0] M_AXISCFG_tdata;
   logic        M_AXISCFG_tvalid;
   logic        configuration_mode;
   logic [2:0]  configuration_axis;
   logic        configuration_send;
   logic        busy;
   logic        done;
   logic        error;
   logic [3:0]  skipped;

   int checks;
   int errors;

   int plan_ack [NUM_AXES];
   int plan_done[NUM_AXES];
   bit ack_never [NUM_AXES];
   bit done_never[NUM_AXES];
   int ds_force;

   int         exp_axes[$];
   int         exp_len[$];
   logic [3:0] exp_skipped;
   logic       exp_error;

   int          done_count;
   int          send_bad;
   int          cyc;
   int          fall_cyc;
   int          fall_to_done;
   int          stable;
   int          cur_len;
   logic        send_prev;
   logic [31:0] last_tdata;
   logic [2:0]  last_axis;
   int          frame_axis_q[$];
   int          frame_len_q[$];
   int          frame_stable_q[$];
   logic [31:0] frame_data_q[$];

   axis_ad5791_cfg_seq dut (
      .a_clk              (a_clk),
      .a_rst              (a_rst),
      .start              (start),
      .ctrl_word          (ctrl_word),
      .dac_ready          (dac_ready),
      .M_AXISCFG_tdata    (M_AXISCFG_tdata),
      .M_AXISCFG_tvalid   (M_AXISCFG_tvalid),
      .configuration_mode (configuration_mode),
      .configuration_axis (configuration_axis),
      .configuration_send (configuration_send),
      .busy               (busy),
      .done               (done),
      .error              (error),
      .skipped            (skipped)
   );

   // 125 MHz clock.
   initial begin
      a_clk = 1'b0;
      forever #4 a_clk = ~a_clk;
   end

   // Hard stop in case something wedges beyond every bounded wait.
   initial begin
      #(750_000);
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Downstream SPI driver model. It notices a new send request while idle,
   // waits the planned number of cycles before dropping ready, then stays
   // busy for the planned time before raising ready again. "Never" entries
   // leave ready high (no frame) or hold it low forever (hung driver).
   // ds_force lets the main sequence pin ready high (1) or low (2).
   initial begin : downstreamModel
      int phase;
      int cnt;
      int ax;
      phase     = 0;
      cnt       = 0;
      ax        = 0;
      dac_ready = 1'b1;
      forever begin
         @(negedge a_clk);
         if (ds_force != 0) begin
            dac_ready = (ds_force == 1);
            phase     = 0;
         end else begin
            case (phase)
               0: begin
                  if (configuration_send && dac_ready) begin
                     ax = int'(configuration_axis) % NUM_AXES;
                     if (!ack_never[ax]) begin
                        cnt   = plan_ack[ax];
                        phase = 1;
                     end
                  end
               end
               1: begin
                  cnt = cnt - 1;
                  if (cnt <= 0) begin
                     dac_ready = 1'b0;
                     if (done_never[ax]) begin
                        phase = 3;
                     end else begin
                        cnt   = plan_done[ax];
                        phase = 2;
                     end
                  end
               end
               2: begin
                  cnt = cnt - 1;
                  if (cnt <= 0) begin
                     dac_ready = 1'b1;
                     phase     = 0;
                  end
               end
               default: begin
                  dac_ready = 1'b0;
               end
            endcase
         end
      end
   end

   // Passive monitor. Records every frame (axis, data, how long the data had
   // been stable beforehand, how long send was held), counts done pulses and
   // any send request seen without valid data, and measures the time from
   // the last send release to the done pulse.
   initial begin : monitor
      done_count   = 0;
      send_bad     = 0;
      cyc          = 0;
      fall_cyc     = 0;
      fall_to_done = 0;
      stable       = 0;
      cur_len      = 0;
      send_prev    = 1'b0;
      last_tdata   = '0;
      last_axis    = '0;
      forever begin
         @(negedge a_clk);
         cyc = cyc + 1;
         if (done === 1'b1) begin
            done_count   = done_count + 1;
            fall_to_done = cyc - fall_cyc;
         end
         if (configuration_send === 1'b1 && M_AXISCFG_tvalid !== 1'b1)
            send_bad = send_bad + 1;
         if (M_AXISCFG_tvalid === 1'b1) begin
            if (M_AXISCFG_tdata === last_tdata && configuration_axis === last_axis && stable > 0)
               stable = stable + 1;
            else
               stable = 1;
         end else begin
            stable = 0;
         end
         last_tdata = M_AXISCFG_tdata;
         last_axis  = configuration_axis;
         if (configuration_send === 1'b1 && !send_prev) begin
            frame_axis_q.push_back(int'(configuration_axis));
            frame_data_q.push_back(M_AXISCFG_tdata);
            frame_stable_q.push_back(stable - 1);
            cur_len = 0;
         end
         if (configuration_send === 1'b1)
            cur_len = cur_len + 1;
         if (configuration_send !== 1'b1 && send_prev) begin
            frame_len_q.push_back(cur_len);
            fall_cyc = cyc;
         end
         send_prev = (configuration_send === 1'b1);
      end
   end

   // Single comparison point: counts the check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks = checks + 1;
      if (observed !== expected) begin
         errors = errors + 1;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // All outputs are expected at their reset/idle value of zero.
   task automatic checkIdleZero(input string tag);
      checkOutput({tag, "_tdata"}, M_AXISCFG_tdata, 32'd0);
      checkOutput({tag, "_tvalid"}, 32'(M_AXISCFG_tvalid), 32'd0);
      checkOutput({tag, "_mode"}, 32'(configuration_mode), 32'd0);
      checkOutput({tag, "_axis"}, 32'(configuration_axis), 32'd0);
      checkOutput({tag, "_send"}, 32'(configuration_send), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_done"}, 32'(done), 32'd0);
      checkOutput({tag, "_error"}, 32'(error), 32'd0);
      checkOutput({tag, "_skipped"}, 32'(skipped), 32'd0);
   endtask

   // Every axis acknowledges after ackDelay cycles and finishes after
   // doneDelay cycles.
   task automatic setPlan(input int ackDelay, input int doneDelay);
      for (int a = 0; a < NUM_AXES; a++) begin
         plan_ack[a]   = ackDelay;
         plan_done[a]  = doneDelay;
         ack_never[a]  = 1'b0;
         done_never[a] = 1'b0;
      end
   endtask

   task automatic setRandomPlan();
      for (int a = 0; a < NUM_AXES; a++) begin
         plan_ack[a]   = int'($urandom_range(1, 40));
         plan_done[a]  = int'($urandom_range(1, 300));
         ack_never[a]  = ($urandom_range(0, 4) == 0);
         done_never[a] = ($urandom_range(0, 7) == 0);
      end
   endtask

   // Reference outcome of one run, straight from the plan: axes are visited
   // in order; an unacknowledged send costs one send cycle plus the full
   // acknowledge window and marks the axis skipped; an acknowledged send is
   // held until the cycle after the driver drops ready; a driver that never
   // finishes ends the run with an error right after that axis.
   task automatic computeExpected();
      exp_axes.delete();
      exp_len.delete();
      exp_skipped = '0;
      exp_error   = 1'b0;
      for (int a = 0; a < NUM_AXES; a++) begin
         exp_axes.push_back(a);
         if (ack_never[a]) begin
            exp_skipped[a] = 1'b1;
            exp_len.push_back(1 + ACK_TIMEOUT);
         end else begin
            exp_len.push_back(plan_ack[a] + 1);
            if (done_never[a]) begin
               exp_error = 1'b1;
               break;
            end
         end
      end
   endtask

   // One complete run: start it (optionally with start already high across
   // a reset release), optionally inject a second start edge while busy,
   // keep start held after done and compare everything seen with the
   // reference outcome.
   task automatic applyStimulus(input logic [23:0] ctrl, input bit glitch,
                                input bit thruReset);
      int baseDone;
      int baseFrame;
      int baseLen;
      int baseBad;
      int glitchAt;
      int idx;
      bit gotDone;
      computeExpected();
      ds_force = 1;
      repeat (2) @(negedge a_clk);
      ds_force  = 0;
      baseDone  = done_count;
      baseFrame = frame_axis_q.size();
      baseLen   = frame_len_q.size();
      baseBad   = send_bad;
      ctrl_word = ctrl;
      if (thruReset) begin
         a_rst = 1'b1;
         start = 1'b1;
         repeat (2) @(negedge a_clk);
         a_rst = 1'b0;
      end else begin
         start = 1'b1;
      end
      gotDone  = 1'b0;
      glitchAt = int'($urandom_range(20, 300));
      for (int k = 0; k < 6000 && !gotDone; k++) begin
         @(negedge a_clk);
         if (thruReset && k == 0)
            checkOutput("start_thru_reset_busy", 32'(busy), 32'd1);
         if (done_count > baseDone)
            gotDone = 1'b1;
         if (glitch && k == glitchAt && busy && !done)
            start = 1'b0;
         if (glitch && k == glitchAt + 1)
            start = 1'b1;
      end
      checkOutput("done_seen", 32'(gotDone), 32'd1);
      repeat (6) @(negedge a_clk);
      checkOutput("done_pulses", 32'(done_count - baseDone), 32'd1);
      checkOutput("no_retrigger_busy", 32'(busy), 32'd0);
      start = 1'b0;
      checkOutput("frames", 32'(frame_axis_q.size() - baseFrame), 32'(exp_axes.size()));
      for (int i = 0; i < exp_axes.size(); i++) begin
         idx = baseFrame + i;
         if (idx < frame_axis_q.size()) begin
            checkOutput("frame_axis", 32'(frame_axis_q[idx]), 32'(exp_axes[i]));
            checkOutput("frame_tdata", frame_data_q[idx], 32'(ctrl));
            checkOutput("frame_settled", 32'(frame_stable_q[idx] >= MIN_SETTLE), 32'd1);
         end
         if (baseLen + i < frame_len_q.size())
            checkOutput("frame_send_len", 32'(frame_len_q[baseLen + i]), 32'(exp_len[i]));
      end
      checkOutput("skipped", 32'(skipped), 32'(exp_skipped));
      checkOutput("error", 32'(error), 32'(exp_error));
      checkOutput("end_mode", 32'(configuration_mode), 32'd0);
      checkOutput("end_tvalid", 32'(M_AXISCFG_tvalid), 32'd0);
      checkOutput("end_send", 32'(configuration_send), 32'd0);
      checkOutput("send_without_tvalid", 32'(send_bad - baseBad), 32'd0);
      if (exp_error)
         checkOutput("done_timeout_len", 32'(fall_to_done), 32'(DONE_TIMEOUT));
   endtask

   // Reset pulsed while axis 1 is in its busy phase: the run must stop dead
   // with every output back to zero and no done pulse.
   task automatic abortRun(input logic [23:0] ctrl);
      int  baseDone;
      bit  found;
      setPlan(12, 300);
      ds_force = 1;
      repeat (2) @(negedge a_clk);
      ds_force  = 0;
      baseDone  = done_count;
      ctrl_word = ctrl;
      start     = 1'b1;
      found     = 1'b0;
      for (int k = 0; k < 3000 && !found; k++) begin
         @(negedge a_clk);
         if (configuration_axis == 3'd1 && configuration_send)
            found = 1'b1;
      end
      checkOutput("abort_reach_axis1", 32'(found), 32'd1);
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         @(negedge a_clk);
         if (!configuration_send)
            found = 1'b1;
      end
      checkOutput("abort_ack_axis1", 32'(found), 32'd1);
      repeat (20) @(negedge a_clk);
      checkOutput("abort_busy_before", 32'(busy), 32'd1);
      a_rst    = 1'b1;
      start    = 1'b0;
      ds_force = 1;
      @(negedge a_clk);
      checkIdleZero("abort");
      checkOutput("abort_no_done", 32'(done_count - baseDone), 32'd0);
      a_rst = 1'b0;
      repeat (5) @(negedge a_clk);
      checkOutput("abort_stays_idle", 32'(busy), 32'd0);
      checkOutput("abort_no_done_after", 32'(done_count - baseDone), 32'd0);
   endtask

   // Main sequence: reset state, the three reference scenarios, ignored
   // starts, abort by reset, start across reset, then randomized runs.
   initial begin : mainSequence
      checks    = 0;
      errors    = 0;
      a_rst     = 1'b1;
      start     = 1'b0;
      ctrl_word = '0;
      ds_force  = 1;
      setPlan(10, 200);
      repeat (3) @(negedge a_clk);
      checkIdleZero("reset");
      a_rst = 1'b0;
      repeat (2) @(negedge a_clk);
      checkIdleZero("post_reset");

      $display("[TB] nominal run, all axes acknowledged");
      setPlan(10, 200);
      applyStimulus(24'h200012, 1'b0, 1'b0);

      $display("[TB] axis 2 never acknowledged, extra start edge while busy");
      setPlan(10, 200);
      ack_never[2] = 1'b1;
      applyStimulus(24'h200012, 1'b1, 1'b0);

      $display("[TB] driver hangs after axis 1 acknowledge");
      setPlan(10, 200);
      done_never[1] = 1'b1;
      applyStimulus(24'h200012, 1'b0, 1'b0);
      repeat (10) @(negedge a_clk);
      checkOutput("error_sticky", 32'(error), 32'd1);

      $display("[TB] start edge while driver not ready");
      ds_force = 2;
      repeat (2) @(negedge a_clk);
      start = 1'b1;
      repeat (3) @(negedge a_clk);
      checkOutput("start_not_ready_ignored", 32'(busy), 32'd0);
      ds_force = 1;
      repeat (3) @(negedge a_clk);
      checkOutput("held_start_no_trigger", 32'(busy), 32'd0);
      start = 1'b0;
      @(negedge a_clk);

      $display("[TB] reset during axis 1 busy phase");
      abortRun(24'h0ABCDE);
      setPlan(10, 200);
      applyStimulus(24'h1F00A5, 1'b0, 1'b0);

      $display("[TB] start held high through reset release");
      setPlan(5, 50);
      applyStimulus(24'h3C3C3C, 1'b0, 1'b1);

      $display("[TB] randomized runs");
      for (int r = 0; r < 10; r++) begin
         setRandomPlan();
         applyStimulus(24'($urandom), bit'($urandom_range(0, 1)), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
